ebu_arbiter: RTL
================

Name: ebu_arbiter

Overview:
- Two-master AHB arbiter in the external bus unit. It shares one AHB master port between the IFU and LSU bus/cache controllers.
- Each requester presents a full AHB address phase (HTRANS/HBURST/HWRITE/HADDR/HSIZE). The arbiter grants one requester at a time and muxes its address phase to the bus.
- The non-owner sees HREADY low, so it holds its request. Ownership changes only on transaction boundaries, so bursts and pipelined transfers are never split.

Parameters:
- PA_BITS, 34, physical address width of HADDR.

Ports:
- clk  in  1  bus clock (same as HCLK)
- reset  in  1  synchronous, active-high reset
- IFUHTRANS  in  2  IFU transfer type
- IFUHBURST  in  3  IFU burst type
- IFUHWRITE  in  1  IFU write
- IFUHSIZE  in  3  IFU size
- IFUHADDR  in  PA_BITS  IFU address
- LSUHTRANS/LSUHBURST/LSUHWRITE/LSUHSIZE/LSUHADDR  in  2/3/1/3/PA_BITS  same fields for the LSU
- HREADY  in  1  bus ready
- HTRANS  out  2  muxed transfer type
- HBURST  out  3  muxed burst type
- HWRITE  out  1  muxed write
- HSIZE  out  3  muxed size
- HADDR  out  PA_BITS  muxed address
- IFUHREADY  out  1  gated ready to IFU
- LSUHREADY  out  1  gated ready to LSU
- DataOwnerLSU  out  1  1: current data phase belongs to the LSU (HRDATA capture steering)
- BurstErr  out  1  owner ended a fixed-length burst early

Behaviour:
- Reset is synchronous and active-high.
  - State = ARB, DataPending = 0, BeatsLeft = 0, LastGrant = IFU, DataOwnerLSU = 0, BurstErr = 0.
  - HTRANS = IDLE while no requester is active.
- Request definitions: IFUReq = IFUHTRANS[1]; LSUReq = LSUHTRANS[1].
- State ARB (bus free, no data phase pending):
  - Winner is selected combinationally; the address phase muxed to the bus is the winner's, or IDLE if none.
  - The winner sees HREADY; the loser's ready is 0.
  - Winner NONSEQ accepted (HREADY=1) -> winner's OWN state; LastGrant <= winner.
  - No request -> remain in ARB with HTRANS=IDLE and all other outputs driven from LSU inputs.
- State IFU_OWN / LSU_OWN:
  - Bus carries the owner's signals. Owner ready = HREADY; other requester ready = 0.
  - Owner HTRANS == IDLE and (~DataPending | HREADY) -> ARB. The switch costs one IDLE address cycle.
  - Otherwise stay, including back-to-back NONSEQ from the owner.
  - BUSY does not release ownership.
- DataPending is updated every cycle HREADY=1: DataPending <= HTRANS[1] of the bus.
  - It holds while HREADY=0.
  - DataOwnerLSU is loaded with (owner==LSU) on every accepted address phase.
- Burst tracking:
  - On an accepted NONSEQ, BeatsLeft loads 0/3/7/15 for HBURST 000/011/101/111.
  - INCR (001) loads 0 and is not checked.
  - Each accepted SEQ decrements BeatsLeft. BeatsLeft is 4 bits and saturates at 0.
  - BurstErr pulses for one cycle when BeatsLeft != 0 and the owner presents IDLE or NONSEQ with HREADY=1.
  - Ownership is never released while BeatsLeft != 0. An early IDLE still flags BurstErr, then follows the normal release rule.
- Arbitration with both requesting in ARB: the LSU wins (fixed priority, default).
- Reset mid-burst: return to ARB immediately; no pending data is tracked after reset.
- The non-owner's inputs never reach the bus. Its ready stays 0 for the entire ownership period.

Optional Feature:
- Macro: EBU_ROUND_ROBIN_EN
- Defined: on simultaneous requests in ARB, the requester != LastGrant wins. Single requests are granted regardless of LastGrant.
- Undefined: LSU has fixed priority and LastGrant is unused (still reset, but has no effect).

Test Plan:
- Reset, then IFU single NONSEQ read at 0x8000_0000 with HREADY=1 -> same-cycle HTRANS=10 and HADDR=0x8000_0000, IFUHREADY=1, LSUHREADY=0; next cycle state IFU_OWN, DataOwnerLSU=0.
- Both NONSEQ in ARB -> LSU granted. With EBU_ROUND_ROBIN_EN and LastGrant=LSU -> IFU granted.
- IFU INCR4 (HBURST=011) in progress; LSU requests at beat 2 -> LSUHREADY=0 through all 4 beats. LSU address appears one cycle after IFU drives IDLE with its last data phase done.
- Owner INCR8 issues IDLE after 3 SEQ beats -> BurstErr=1 for exactly one cycle.
- HREADY held 0 for 3 cycles during the owner's final data phase while the owner drives IDLE -> no switch until HREADY=1; DataOwnerLSU is stable throughout.
- Assert reset during LSU burst beat 2 -> next cycle state ARB, HTRANS=00 with no requests, BurstErr=0.

Source files
------------

// File: rtl/ebu_arbiter.sv
// ebu_arbiter: two-master AHB arbiter sharing one master port between the IFU and LSU.
// Ownership changes only on transaction boundaries; fixed-length bursts are tracked so
// an early termination raises BurstErr.
// Optional build macro: EBU_ROUND_ROBIN_EN (simultaneous requests go to the requester
// that did not win last time; otherwise the LSU has fixed priority).
module ebu_arbiter #(
   parameter int unsigned PA_BITS = 34
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         IFUHTRANS,
   input  logic [2:0]         IFUHBURST,
   input  logic               IFUHWRITE,
   input  logic [2:0]         IFUHSIZE,
   input  logic [PA_BITS-1:0] IFUHADDR,
   input  logic [1:0]         LSUHTRANS,
   input  logic [2:0]         LSUHBURST,
   input  logic               LSUHWRITE,
   input  logic [2:0]         LSUHSIZE,
   input  logic [PA_BITS-1:0] LSUHADDR,
   input  logic               HREADY,
   output logic [1:0]         HTRANS,
   output logic [2:0]         HBURST,
   output logic               HWRITE,
   output logic [2:0]         HSIZE,
   output logic [PA_BITS-1:0] HADDR,
   output logic               IFUHREADY,
   output logic               LSUHREADY,
   output logic               DataOwnerLSU,
   output logic               BurstErr
);

   typedef enum logic [1:0] {StArb, StIfuOwn, StLsuOwn} state_e;

   localparam logic [1:0] TrIdle   = 2'b00;
   localparam logic [1:0] TrNonseq = 2'b10;
   localparam logic [1:0] TrSeq    = 2'b11;

`ifdef EBU_ROUND_ROBIN_EN
   localparam logic RrEn = 1'b1;
`else
   localparam logic RrEn = 1'b0;
`endif

   state_e     state_q, state_d;
   logic       data_pending_q, data_pending_d;
   logic [3:0] beats_left_q, beats_left_d;
   logic       last_grant_lsu_q, last_grant_lsu_d;
   logic       data_owner_lsu_q, data_owner_lsu_d;
   logic       burst_err_q, burst_err_d;

   logic       ifu_req, lsu_req, grant_lsu, sel_lsu;
   logic [1:0] htrans_bus;
   logic [2:0] hburst_bus;

   assign ifu_req = IFUHTRANS[1];
   assign lsu_req = LSUHTRANS[1];

   // Arbitration winner in ArB; with no requester the LSU side is selected by default
   always_comb begin
      grant_lsu = lsu_req & (~RrEn | ~ifu_req | ~last_grant_lsu_q);
      case (state_q)
         StArb:    sel_lsu = grant_lsu | ~ifu_req;
         StIfuOwn: sel_lsu = 1'b0;
         StLsuOwn: sel_lsu = 1'b1;
         default:  sel_lsu = 1'b1;
      endcase
   end

   // Address-phase mux and ready gating
   always_comb begin
      htrans_bus = sel_lsu ? LSUHTRANS : IFUHTRANS;
      if ((state_q == StArb) && !(ifu_req || lsu_req)) begin
         htrans_bus = TrIdle;
      end
      hburst_bus = sel_lsu ? LSUHBURST : IFUHBURST;
      HTRANS     = htrans_bus;
      HBURST     = hburst_bus;
      HWRITE     = sel_lsu ? LSUHWRITE : IFUHWRITE;
      HSIZE      = sel_lsu ? LSUHSIZE  : IFUHSIZE;
      HADDR      = sel_lsu ? LSUHADDR  : IFUHADDR;
      LSUHREADY  = sel_lsu & HREADY;
      IFUHREADY  = ~sel_lsu & HREADY;
   end

   // Next-state: ownership, data-phase tracking and burst beat accounting
   always_comb begin
      state_d          = state_q;
      data_pending_d   = data_pending_q;
      beats_left_d     = beats_left_q;
      last_grant_lsu_d = last_grant_lsu_q;
      data_owner_lsu_d = data_owner_lsu_q;
      burst_err_d      = 1'b0;

      if (HREADY) begin
         data_pending_d = htrans_bus[1];
         // Steering only changes for real transfers so an idle bus keeps the last owner
         if (htrans_bus[1]) begin
            data_owner_lsu_d = sel_lsu;
         end
         case (htrans_bus)
            TrNonseq: begin
               burst_err_d = (beats_left_q != 4'd0);
               case (hburst_bus[2:1])
                  2'b00:   beats_left_d = 4'd0;
                  2'b01:   beats_left_d = 4'd3;
                  2'b10:   beats_left_d = 4'd7;
                  default: beats_left_d = 4'd15;
               endcase
            end
            TrSeq: begin
               beats_left_d = (beats_left_q == 4'd0) ? 4'd0 : beats_left_q - 4'd1;
            end
            TrIdle: begin
               burst_err_d  = (beats_left_q != 4'd0);
               beats_left_d = 4'd0;
            end
            default: ;
         endcase
      end

      case (state_q)
         StArb: begin
            if (HREADY && (ifu_req || lsu_req)) begin
               state_d          = sel_lsu ? StLsuOwn : StIfuOwn;
               last_grant_lsu_d = sel_lsu;
            end
         end
         default: begin
            // An early IDLE clears the beat count, so release happens the cycle after
            if ((htrans_bus == TrIdle) && (!data_pending_q || HREADY) &&
                (beats_left_q == 4'd0)) begin
               state_d = StArb;
            end
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StArb;
         data_pending_q   <= 1'b0;
         beats_left_q     <= 4'd0;
         last_grant_lsu_q <= 1'b0;
         data_owner_lsu_q <= 1'b0;
         burst_err_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         data_pending_q   <= data_pending_d;
         beats_left_q     <= beats_left_d;
         last_grant_lsu_q <= last_grant_lsu_d;
         data_owner_lsu_q <= data_owner_lsu_d;
         burst_err_q      <= burst_err_d;
      end
   end

   assign DataOwnerLSU = data_owner_lsu_q;
   assign BurstErr     = burst_err_q;

endmodule
